// File: rtl/ofdm_pkg.sv
// Shared OFDM transmit-chain definitions: modulation widths, mapper state
// encoding and constellation level helpers (constant arithmetic only).
package ofdm_pkg;

  localparam int BPS_QPSK  = 2;
  localparam int BPS_QAM16 = 4;

  localparam logic ST_IDLE_ENC = 1'b0;
  localparam logic ST_MAP_ENC  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE_ENC,
    MAP  = ST_MAP_ENC
  } state_e;

  // QPSK: bit 0 -> +A, bit 1 -> -A, with A = 2^(awidth-2)
  function automatic int qpsk_level(input logic b, input int awidth);
    int a;
    a = 32'sd1 <<< (awidth - 2);
    if (b) begin
      return -a;
    end else begin
      return a;
    end
  endfunction

  // 16-QAM Gray axis: 00 -> -3U, 01 -> -U, 11 -> +U, 10 -> +3U, U = 2^(awidth-3)
  function automatic int qam_level(input logic [1:0] bits2, input int awidth);
    int u;
    u = 32'sd1 <<< (awidth - 3);
    case (bits2)
      2'b00:   return -((u <<< 1) + u);
      2'b01:   return -u;
      2'b11:   return u;
      2'b10:   return (u <<< 1) + u;
      default: return 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/qam_mapper_lut.sv
// Combinational constellation lookup: one BPS-bit symbol group to a signed
// (I,Q) point. Only QPSK and 16-QAM groupings elaborate.
module qam_lut
  import ofdm_pkg::*;
#(
  parameter int BPS    = 2,
  parameter int AWIDTH = 8
) (
  input  logic [BPS-1:0]           group_i,
  output logic signed [AWIDTH-1:0] i_o,
  output logic signed [AWIDTH-1:0] q_o
);

  generate
    if (BPS == BPS_QPSK) begin : g_qpsk
      // I from bit 0, Q from bit 1
      always_comb begin
        i_o = AWIDTH'(qpsk_level(group_i[0], AWIDTH));
        q_o = AWIDTH'(qpsk_level(group_i[1], AWIDTH));
      end
    end else if (BPS == BPS_QAM16) begin : g_qam16
      // I from bits [1:0], Q from bits [3:2]
      always_comb begin
        i_o = AWIDTH'(qam_level(group_i[1:0], AWIDTH));
        q_o = AWIDTH'(qam_level(group_i[3:2], AWIDTH));
      end
    end else begin : g_bad_bps
      $error("qam_lut: BPS must be 2 (QPSK) or 4 (16-QAM)");
      // Unreachable configuration; outputs tied off
      always_comb begin
        i_o = '0;
        q_o = '0;
      end
    end
  endgenerate

endmodule

// File: rtl/qam_mapper.sv
// Frame-to-symbol mapper: accepts one packed frame of NSYM groups and streams
// one mapped constellation point per cycle, zero-bubble across frames.
module qam_mapper
  import ofdm_pkg::*;
#(
  parameter int NSYM    = 32,
  parameter int BPS     = 2,
  parameter int AWIDTH  = 8,
  parameter int FRAME_W = NSYM * BPS,
  parameter int IDXW    = (NSYM > 1) ? $clog2(NSYM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FRAME_W-1:0]       i_frame,
  input  logic                     i_valid,
  output logic                     i_ready,
  output logic signed [AWIDTH-1:0] o_i,
  output logic signed [AWIDTH-1:0] o_q,
  output logic [IDXW-1:0]          o_idx,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     o_ready
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSYM - 1);

  state_e                    state_q;
  logic [FRAME_W-1:0]        frame_q;
  logic [IDXW-1:0]           sym_ctr_q;
  logic signed [AWIDTH-1:0]  o_i_q;
  logic signed [AWIDTH-1:0]  o_q_q;
  logic                      o_last_q;
  logic                      o_valid_q;

  logic                      out_hs;
  logic                      ready;
  logic                      load;
  logic [IDXW-1:0]           ctr_d;
  logic [IDXW-1:0]           src_idx;
  logic [FRAME_W-1:0]        src_frame;
  logic [BPS-1:0]            group_d;
  logic signed [AWIDTH-1:0]  lut_i_d;
  logic signed [AWIDTH-1:0]  lut_q_d;

  // Handshake decode and selection of the group mapped into the next sample
  always_comb begin
    out_hs = o_valid_q && o_ready;
    if (state_q == MAP) begin
      ready = out_hs && o_last_q;
    end else begin
      ready = 1'b1;
    end
    load = i_valid && ready;
    if (o_last_q) begin
      ctr_d = '0;
    end else begin
      ctr_d = sym_ctr_q + IDXW'(1);
    end
    // A load always presents group 0 of the incoming frame
    if (load) begin
      src_frame = i_frame;
      src_idx   = '0;
    end else begin
      src_frame = frame_q;
      src_idx   = ctr_d;
    end
    group_d = src_frame[int'(src_idx) * BPS +: BPS];
  end

  qam_lut #(
    .BPS    (BPS),
    .AWIDTH (AWIDTH)
  ) u_lut (
    .group_i (group_d),
    .i_o     (lut_i_d),
    .q_o     (lut_q_d)
  );

  // Mapper FSM with registered sample outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      sym_ctr_q <= '0;
      o_i_q     <= '0;
      o_q_q     <= '0;
      o_last_q  <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            frame_q   <= i_frame;
            sym_ctr_q <= '0;
            o_i_q     <= lut_i_d;
            o_q_q     <= lut_q_d;
            o_last_q  <= (LAST_IDX == '0);
            o_valid_q <= 1'b1;
            state_q   <= MAP;
          end
        end
        MAP: begin
          if (out_hs) begin
            if (!o_last_q) begin
              sym_ctr_q <= ctr_d;
              o_i_q     <= lut_i_d;
              o_q_q     <= lut_q_d;
              o_last_q  <= (ctr_d == LAST_IDX);
            end else if (load) begin
              frame_q   <= i_frame;
              sym_ctr_q <= '0;
              o_i_q     <= lut_i_d;
              o_q_q     <= lut_q_d;
              o_last_q  <= (LAST_IDX == '0);
            end else begin
              sym_ctr_q <= '0;
              o_last_q  <= 1'b0;
              o_valid_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          o_valid_q <= 1'b0;
          o_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign i_ready = ready;
  assign o_i     = o_i_q;
  assign o_q     = o_q_q;
  assign o_idx   = sym_ctr_q;
  assign o_last  = o_last_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Self-checking bench for qam_mapper: QPSK 32-symbol instance plus a 16-QAM
// 16-symbol instance, checked against an arithmetic constellation model.
module tb_qam_mapper;

  localparam int AW = 8;
  localparam int A2 = 2 ** (AW - 2);
  localparam int U4 = 2 ** (AW - 3);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [63:0]        i_frame = 64'd0;
  logic               i_valid = 1'b0;
  logic               i_ready;
  logic signed [7:0]  o_i, o_q;
  logic [4:0]         o_idx;
  logic               o_last, o_valid;
  logic               o_ready = 1'b1;

  logic [63:0]        i_frame16 = 64'd0;
  logic               i_valid16 = 1'b0;
  logic               i_ready16;
  logic signed [7:0]  o_i16, o_q16;
  logic [3:0]         o_idx16;
  logic               o_last16, o_valid16;
  logic               o_ready16 = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              v, r, ir, last;
    logic signed [7:0] i, q;
    logic [4:0]        idx;
  } rec_t;
  rec_t trace[$];

  always #5 clk = ~clk;

  qam_mapper #(.NSYM(32), .BPS(2), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .i_frame(i_frame), .i_valid(i_valid), .i_ready(i_ready),
    .o_i(o_i), .o_q(o_q), .o_idx(o_idx), .o_last(o_last), .o_valid(o_valid), .o_ready(o_ready)
  );

  qam_mapper #(.NSYM(16), .BPS(4), .AWIDTH(AW)) dut16 (
    .clk(clk), .rst(rst), .i_frame(i_frame16), .i_valid(i_valid16), .i_ready(i_ready16),
    .o_i(o_i16), .o_q(o_q16), .o_idx(o_idx16), .o_last(o_last16), .o_valid(o_valid16),
    .o_ready(o_ready16)
  );

  // Reference model: QPSK point of group k
  function automatic void model_qpsk(input logic [63:0] f, input int k, output int ei, output int eq);
    ei = f[2*k]   ? -A2 : A2;
    eq = f[2*k+1] ? -A2 : A2;
  endfunction

  // Reference model: Gray rank 0..3 along the axis gives level (2*rank-3)*U
  function automatic int gray_level(input logic [1:0] b);
    int rank;
    rank = (b == 2'b00) ? 0 : (b == 2'b01) ? 1 : (b == 2'b11) ? 2 : 3;
    return (2 * rank - 3) * U4;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Accept one frame on the QPSK instance and record every cycle until 32 samples
  // have been handed off. mode: 0 ready high, 1 ready toggling, 2 ready random.
  task automatic run_frame(input logic [63:0] f, input int mode, input bit junk, output bit ok);
    int hs;
    logic r;
    trace.delete();
    i_valid = 1'b1;
    i_frame = f;
    o_ready = 1'b1;
    @(posedge clk); #1;
    hs = 0;
    for (int c = 0; c < 400 && hs < 32; c++) begin
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = c[0];
      else                r = 1'($urandom_range(0, 1));
      o_ready = r;
      i_valid = junk && (hs != 31);
      i_frame = rand64();
      #2;
      trace.push_back('{v: o_valid, r: o_ready, ir: i_ready, last: o_last,
                        i: o_i, q: o_q, idx: o_idx});
      if (o_valid && o_ready) hs++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    ok = (hs == 32);
  endtask

  task automatic test_reset();
    checks++;
    if (o_valid !== 1'b0 || o_last !== 1'b0 || o_i !== 8'sd0 || o_q !== 8'sd0 || o_idx !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs got v%0b l%0b i%0d q%0d idx%0d want all zero",
               o_valid, o_last, o_i, o_q, o_idx);
    end
    checks++;
    if (o_valid16 !== 1'b0 || o_idx16 !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs16 got v%0b idx%0d want v0 idx0", o_valid16, o_idx16);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got i_ready%0b o_valid%0b want 1 0", i_ready, o_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_qpsk_pattern();
    bit ok;
    int k, ei, eq;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_accept_valid got %0b want 0", o_valid);
    end
    run_frame(64'h00000000000000E4, 0, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL qpsk_timeout got fewer than 32 samples want 32");
    end
    checks++;
    if (trace[0].v !== 1'b1 || trace[0].idx !== 5'd0) begin
      errors++;
      $display("FAIL qpsk_latency got v%0b idx%0d want v1 idx0", trace[0].v, trace[0].idx);
    end
    k = 0;
    foreach (trace[n]) begin
      if (trace[n].v && trace[n].r) begin
        model_qpsk(64'h00000000000000E4, k, ei, eq);
        checks++;
        if (trace[n].i !== ei || trace[n].q !== eq || trace[n].idx !== k || trace[n].last !== (k == 31)) begin
          errors++;
          $display("FAIL qpsk_E4 k%0d got (%0d,%0d) idx%0d last%0b want (%0d,%0d) idx%0d last%0b",
                   k, trace[n].i, trace[n].q, trace[n].idx, trace[n].last, ei, eq, k, k == 31);
        end
        k++;
      end
    end
  endtask

  task automatic test_qam16();
    logic [63:0] f;
    int ei, eq;
    for (int t = 0; t < 2; t++) begin
      f = (t == 0) ? {{14{4'hF}}, 4'h2, 4'h9} : rand64();
      i_valid16 = 1'b1;
      i_frame16 = f;
      o_ready16 = 1'b1;
      @(posedge clk); #1;
      i_valid16 = 1'b0;
      for (int k = 0; k < 16; k++) begin
        #2;
        ei = gray_level(f[4*k +: 2]);
        eq = gray_level(f[4*k+2 +: 2]);
        checks++;
        if (o_valid16 !== 1'b1 || o_idx16 !== k || o_last16 !== (k == 15) || o_i16 !== ei || o_q16 !== eq) begin
          errors++;
          $display("FAIL qam16 t%0d k%0d got v%0b (%0d,%0d) idx%0d last%0b want v1 (%0d,%0d) idx%0d last%0b",
                   t, k, o_valid16, o_i16, o_q16, o_idx16, o_last16, ei, eq, k, k == 15);
        end
        @(posedge clk); #1;
      end
      #2;
      checks++;
      if (o_valid16 !== 1'b0) begin
        errors++;
        $display("FAIL qam16_end got o_valid %0b want 0", o_valid16);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] f0, f1, fc;
    int k, ei, eq;
    f0 = rand64();
    f1 = rand64();
    i_valid = 1'b1;
    i_frame = f0;
    o_ready = 1'b1;
    @(posedge clk); #1;
    i_frame = f1;
    for (int n = 0; n < 64; n++) begin
      #2;
      k  = n % 32;
      fc = (n < 32) ? f0 : f1;
      model_qpsk(fc, k, ei, eq);
      checks++;
      if (o_valid !== 1'b1 || o_idx !== k || o_i !== ei || o_q !== eq) begin
        errors++;
        $display("FAIL b2b_sample n%0d got v%0b (%0d,%0d) idx%0d want v1 (%0d,%0d) idx%0d",
                 n, o_valid, o_i, o_q, o_idx, ei, eq, k);
      end
      checks++;
      if (i_ready !== (k == 31)) begin
        errors++;
        $display("FAIL b2b_i_ready n%0d got %0b want %0b", n, i_ready, k == 31);
      end
      @(posedge clk); #1;
      if (n == 31) i_valid = 1'b0;
    end
    #2;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got o_valid %0b want 0", o_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [63:0] f;
    bit ok;
    int k, ei, eq;
    f = rand64();
    run_frame(f, 1, 1'b0, ok);
    k = 0;
    foreach (trace[n]) begin
      if (n > 0 && trace[n-1].v && !trace[n-1].r) begin
        checks++;
        if (trace[n].i !== trace[n-1].i || trace[n].q !== trace[n-1].q ||
            trace[n].idx !== trace[n-1].idx || trace[n].last !== trace[n-1].last || trace[n].v !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold cyc%0d got (%0d,%0d) idx%0d want (%0d,%0d) idx%0d",
                   n, trace[n].i, trace[n].q, trace[n].idx, trace[n-1].i, trace[n-1].q, trace[n-1].idx);
        end
      end
      if (trace[n].v && trace[n].r) begin
        model_qpsk(f, k, ei, eq);
        checks++;
        if (trace[n].i !== ei || trace[n].q !== eq || trace[n].idx !== k) begin
          errors++;
          $display("FAIL stall_sample k%0d got (%0d,%0d) idx%0d want (%0d,%0d) idx%0d",
                   k, trace[n].i, trace[n].q, trace[n].idx, ei, eq, k);
        end
        k++;
      end
    end
    checks++;
    if (!ok || k !== 32) begin
      errors++;
      $display("FAIL stall_count got %0d samples want 32", k);
    end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] f, f2;
    bit ok;
    int c, k, ei, eq;
    f = rand64();
    i_valid = 1'b1;
    i_frame = f;
    o_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    c = 0;
    while (o_idx !== 5'd10 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (o_idx !== 5'd10 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_reach_idx10 got idx%0d v%0b want idx10 v1", o_idx, o_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_idx !== 5'd0 || o_last !== 1'b0 || o_i !== 8'sd0) begin
      errors++;
      $display("FAIL rst_async got v%0b idx%0d last%0b i%0d want 0 0 0 0", o_valid, o_idx, o_last, o_i);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got i_ready%0b v%0b want 1 0", i_ready, o_valid);
    end
    @(posedge clk); #1;
    f2 = rand64();
    run_frame(f2, 0, 1'b0, ok);
    k = 0;
    foreach (trace[n]) begin
      if (trace[n].v && trace[n].r) begin
        model_qpsk(f2, k, ei, eq);
        checks++;
        if (trace[n].i !== ei || trace[n].q !== eq || trace[n].idx !== k) begin
          errors++;
          $display("FAIL rst_next_frame k%0d got (%0d,%0d) idx%0d want (%0d,%0d) idx%0d",
                   k, trace[n].i, trace[n].q, trace[n].idx, ei, eq, k);
        end
        k++;
      end
    end
    checks++;
    if (!ok || k !== 32) begin
      errors++;
      $display("FAIL rst_next_count got %0d samples want 32", k);
    end
  endtask

  task automatic test_no_capture();
    logic [63:0] f;
    bit ok;
    int k, ei, eq;
    f = rand64();
    run_frame(f, 2, 1'b1, ok);
    k = 0;
    foreach (trace[n]) begin
      checks++;
      if (trace[n].ir !== (trace[n].v && trace[n].r && trace[n].last)) begin
        errors++;
        $display("FAIL map_i_ready cyc%0d got %0b want %0b", n, trace[n].ir,
                 trace[n].v && trace[n].r && trace[n].last);
      end
      if (trace[n].v && trace[n].r) begin
        model_qpsk(f, k, ei, eq);
        checks++;
        if (trace[n].i !== ei || trace[n].q !== eq || trace[n].idx !== k) begin
          errors++;
          $display("FAIL no_capture k%0d got (%0d,%0d) idx%0d want (%0d,%0d) idx%0d",
                   k, trace[n].i, trace[n].q, trace[n].idx, ei, eq, k);
        end
        k++;
      end
    end
    #2;
    checks++;
    if (!ok || k !== 32 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_capture_end got %0d samples v%0b want 32 v0", k, o_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_qpsk_pattern();
    test_qam16();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
    test_no_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
